instr_loader: RTL and testbench

Boot-time program loader: the write side of the instruction memory that the fetch stage reads. Accepts a byte stream over a valid/ready handshake and decodes it as a 16-bit word count, N 24-bit instruction words and an XOR checksum. Each assembled word is written to consecutive instruction-memory addresses starting at 0. Holds the processor core in reset via `cpu_hold` until the image is loaded and verified.

---
 rtl/instr_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: parses a count/words/checksum byte stream and
// writes each assembled instruction word into instruction memory.
module instr_loader #(
   parameter int WORD_W = 24,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 65536
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [3:0] S_CNT_HI = 4'd0;
   localparam logic [3:0] S_CNT_LO = 4'd1;
   localparam logic [3:0] S_B0     = 4'd2;
   localparam logic [3:0] S_B1     = 4'd3;
   localparam logic [3:0] S_B2     = 4'd4;
   localparam logic [3:0] S_WRITE  = 4'd5;
   localparam logic [3:0] S_CHK    = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ERR    = 4'd8;

   logic [3:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        xor_q, xor_d;
   logic [WORD_W-9:0] word_q, word_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              ready_state;
   logic              accept;
   logic [15:0]       n_w;
   logic [ADDR_W:0]   idx_inc;

   always_comb begin
      ready_state = 1'b0;
      case (state_q)
         S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_CHK: ready_state = 1'b1;
         default:                                     ready_state = 1'b0;
      endcase
   end

   assign accept  = byte_valid & ready_state;
   assign n_w     = {cnt_q[15:8], byte_data};
   assign idx_inc = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      xor_d   = xor_q;
      word_d  = word_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      error_d = error_q;
      case (state_q)
         S_CNT_HI: if (accept) begin
            cnt_d   = {byte_data, 8'h00};
            xor_d   = xor_q ^ byte_data;
            state_d = S_CNT_LO;
         end
         S_CNT_LO: if (accept) begin
            cnt_d = n_w;
            xor_d = xor_q ^ byte_data;
            if (32'(n_w) > 32'(DEPTH)) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else if (n_w == 16'd0) begin
               state_d = S_CHK;
            end else begin
               state_d = S_B0;
            end
         end
         S_B0, S_B1: if (accept) begin
            word_d  = {word_q[WORD_W-17:0], byte_data};
            xor_d   = xor_q ^ byte_data;
            state_d = (state_q == S_B0) ? S_B1 : S_B2;
         end
         // The write strobe is registered here so it coincides with the WRITE state.
         S_B2: if (accept) begin
            xor_d   = xor_q ^ byte_data;
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = {word_q, byte_data};
            state_d = S_WRITE;
         end
         S_WRITE: begin
            idx_d   = idx_inc[ADDR_W-1:0];
            state_d = (32'(idx_inc) == 32'(cnt_q)) ? S_CHK : S_B0;
         end
         S_CHK: if (accept) begin
            if (byte_data == xor_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_ERR;
               error_d = 1'b1;
            end
         end
         S_DONE, S_ERR: if (reload) begin
            state_d = S_CNT_HI;
            cnt_d   = 16'd0;
            idx_d   = '0;
            xor_d   = 8'h00;
            done_d  = 1'b0;
            error_d = 1'b0;
         end
         default: state_d = S_CNT_HI;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q <= S_CNT_HI;
         cnt_q   <= 16'd0;
         idx_q   <= '0;
         xor_q   <= 8'h00;
         word_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         xor_q   <= xor_d;
         word_q  <= word_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign byte_ready = ready_state & rst;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign done       = done_q;
   assign error      = error_q;
   assign cpu_hold   = (state_q != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: full-depth instance plus a DEPTH=4
// instance for the over-count check.
module tb_instr_loader;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_valid = 1'b0;
   logic        reload = 1'b0;
   logic        byte_ready, mem_we, cpu_hold, done, error;
   logic [15:0] mem_addr;
   logic [23:0] mem_wdata;

   logic [7:0]  b4_data = 8'h00;
   logic        b4_valid = 1'b0;
   logic        reload4 = 1'b0;
   logic        ready4, we4, hold4, done4, err4;
   logic [15:0] addr4;
   logic [23:0] wdata4;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] wr_addr[$];
   logic [23:0] wr_data[$];
   int          dbl = 0;
   int          wr4_cnt = 0;
   logic        we_prev = 1'b0;
   logic [7:0]  stream[$];
   int          base;

   always #5 CLK = ~CLK;

   instr_loader dut (
      .CLK(CLK), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .reload(reload), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   instr_loader #(.DEPTH(4)) dut4 (
      .CLK(CLK), .rst(rst), .byte_data(b4_data), .byte_valid(b4_valid),
      .byte_ready(ready4), .reload(reload4), .mem_we(we4),
      .mem_addr(addr4), .mem_wdata(wdata4), .cpu_hold(hold4),
      .done(done4), .error(err4)
   );

   always @(negedge CLK) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         $display("write addr=0x%04h data=0x%06h", mem_addr, mem_wdata);
         if (we_prev) dbl <= dbl + 1;
      end
      we_prev <= mem_we;
      if (we4) wr4_cnt <= wr4_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Offer one byte until it is accepted; the handshake is decided at the
   // negedge, so the following posedge performs the transfer.
   task automatic send_byte(input bit which, input logic [7:0] b, input bit gaps);
      bit sent = 1'b0;
      logic v;
      for (int i = 0; i < 200 && !sent; i++) begin
         @(negedge CLK);
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (which) begin
            b4_valid = v; b4_data = b;
            if (v && ready4) sent = 1'b1;
         end else begin
            byte_valid = v; byte_data = b;
            if (v && byte_ready) sent = 1'b1;
         end
         if (sent) @(posedge CLK);
      end
      if (!sent) check_eq("send_timeout", 32'(sent), 32'd1);
   endtask

   task automatic send_stream(input bit which, input bit gaps);
      foreach (stream[i]) send_byte(which, stream[i], gaps);
      @(negedge CLK);
      if (which) b4_valid = 1'b0; else byte_valid = 1'b0;
   endtask

   task automatic pulse_reload(input bit which);
      @(negedge CLK);
      if (which) reload4 = 1'b1; else reload = 1'b1;
      @(negedge CLK);
      if (which) reload4 = 1'b0; else reload = 1'b0;
   endtask

   task automatic check_two_words(input string tag, input int b0);
      check_eq({tag, "_wcount"}, 32'(wr_addr.size() - b0), 32'd2);
      if (wr_addr.size() - b0 == 2) begin
         check_eq({tag, "_addr0"}, 32'(wr_addr[b0]),     32'h0);
         check_eq({tag, "_data0"}, 32'(wr_data[b0]),     32'h123456);
         check_eq({tag, "_addr1"}, 32'(wr_addr[b0 + 1]), 32'h1);
         check_eq({tag, "_data1"}, 32'(wr_data[b0 + 1]), 32'hABCDEF);
      end
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      check_eq("rst_ready", 32'(byte_ready), 32'd0);
      check_eq("rst_hold",  32'(cpu_hold),   32'd1);
      check_eq("rst_done",  32'(done),       32'd0);
      check_eq("rst_error", 32'(error),      32'd0);
      check_eq("rst_we",    32'(mem_we),     32'd0);
      check_eq("rst_addr",  32'(mem_addr),   32'd0);
      check_eq("rst_wdata", 32'(mem_wdata),  32'd0);
      rst = 1'b1;
      @(negedge CLK);
      check_eq("post_rst_ready", 32'(byte_ready), 32'd1);

      // Image 1: XOR of 00 02 12 34 56 AB CD EF = FB
      base = wr_addr.size();
      send_byte(0, 8'h00, 0); send_byte(0, 8'h02, 0);
      send_byte(0, 8'h12, 0); send_byte(0, 8'h34, 0); send_byte(0, 8'h56, 0);
      @(negedge CLK);
      check_eq("t1_write_we",    32'(mem_we),     32'd1);
      check_eq("t1_write_ready", 32'(byte_ready), 32'd0);
      check_eq("t1_hold_loading", 32'(cpu_hold),  32'd1);
      send_byte(0, 8'hAB, 0); send_byte(0, 8'hCD, 0); send_byte(0, 8'hEF, 0);
      send_byte(0, 8'hFB, 0);
      @(negedge CLK); byte_valid = 1'b0;
      check_eq("t1_done",  32'(done),     32'd1);
      check_eq("t1_error", 32'(error),    32'd0);
      check_eq("t1_hold",  32'(cpu_hold), 32'd0);
      check_two_words("t1", base);
      check_eq("t1_dbl_we", 32'(dbl), 32'd0);

      // Empty image: 00 00 checksum 00
      pulse_reload(0);
      check_eq("rl_hold", 32'(cpu_hold), 32'd1);
      check_eq("rl_done", 32'(done),     32'd0);
      base = wr_addr.size();
      stream = '{8'h00, 8'h00, 8'h00};
      send_stream(0, 0);
      check_eq("t2_done",   32'(done),  32'd1);
      check_eq("t2_error",  32'(error), 32'd0);
      check_eq("t2_writes", 32'(wr_addr.size() - base), 32'd0);

      // Bad checksum
      pulse_reload(0);
      base = wr_addr.size();
      stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFA};
      send_stream(0, 0);
      check_eq("t3_error", 32'(error),      32'd1);
      check_eq("t3_done",  32'(done),       32'd0);
      check_eq("t3_hold",  32'(cpu_hold),   32'd1);
      check_eq("t3_ready", 32'(byte_ready), 32'd0);
      check_two_words("t3", base);

      // Image 1 again with random valid gaps and bytes offered during WRITE
      pulse_reload(0);
      base = wr_addr.size();
      stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
      send_stream(0, 1);
      check_eq("t5_done",  32'(done),  32'd1);
      check_eq("t5_error", 32'(error), 32'd0);
      check_two_words("t5", base);
      check_eq("t5_dbl_we", 32'(dbl), 32'd0);

      // Reset in the middle of a load
      pulse_reload(0);
      send_byte(0, 8'h00, 0); send_byte(0, 8'h02, 0);
      send_byte(0, 8'h12, 0); send_byte(0, 8'h34, 0);
      @(negedge CLK);
      byte_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_ready", 32'(byte_ready), 32'd0);
      check_eq("mid_rst_hold",  32'(cpu_hold),   32'd1);
      base = wr_addr.size();
      @(negedge CLK);
      rst = 1'b1;
      // XOR of 00 01 AA BB CC = DC
      stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDC};
      send_stream(0, 0);
      check_eq("t6_done", 32'(done), 32'd1);
      check_eq("t6_wcount", 32'(wr_addr.size() - base), 32'd1);
      if (wr_addr.size() - base == 1) begin
         check_eq("t6_addr", 32'(wr_addr[base]), 32'h0);
         check_eq("t6_data", 32'(wr_data[base]), 32'hAABBCC);
      end
      pulse_reload(0);
      check_eq("t6_rl_hold", 32'(cpu_hold), 32'd1);
      send_stream(0, 0);
      check_eq("t6b_done", 32'(done), 32'd1);
      check_eq("t6b_wcount", 32'(wr_addr.size() - base), 32'd2);
      if (wr_addr.size() - base == 2) begin
         check_eq("t6b_addr", 32'(wr_addr[base + 1]), 32'h0);
         check_eq("t6b_data", 32'(wr_data[base + 1]), 32'hAABBCC);
      end

      // DEPTH=4 instance: N=5 is rejected, N=4 is accepted
      stream = '{8'h00, 8'h05};
      send_stream(1, 0);
      check_eq("d4_error",  32'(err4),   32'd1);
      check_eq("d4_done",   32'(done4),  32'd0);
      check_eq("d4_hold",   32'(hold4),  32'd1);
      check_eq("d4_ready",  32'(ready4), 32'd0);
      b4_valid = 1'b1; b4_data = 8'h11;
      repeat (3) @(negedge CLK);
      b4_valid = 1'b0;
      check_eq("d4_ready_later", 32'(ready4),  32'd0);
      check_eq("d4_writes",      32'(wr4_cnt), 32'd0);
      pulse_reload(1);
      stream = '{8'h00, 8'h04};
      send_stream(1, 0);
      check_eq("d4_n4_error", 32'(err4),   32'd0);
      check_eq("d4_n4_ready", 32'(ready4), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
